// File: rtl/sga_pkg.sv
// Shared constants for the LED matrix display path: scan FSM encoding,
// default geometry/timing and the timer width helper.
package sga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    localparam int SGA_ROWS         = 6;
    localparam int SGA_COLS         = 6;
    localparam int SGA_DWELL_CYCLES = 1000;
    localparam int SGA_BLANK_CYCLES = 16;

    // Counter must hold max(dwell, blank) - 1; never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_row_timer.sv
// Loadable down-counter with a zero flag; times both the blanking gap and
// the row dwell of the matrix scan. Holds at zero until reloaded.
module led_row_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             restart,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix driver: double-buffered frames, blank gap before
// every lit row, new frames swapped in only at the end of a complete scan.
module led_matrix_scan
    import sga_pkg::*;
#(
    parameter int ROWS         = SGA_ROWS,
    parameter int COLS         = SGA_COLS,
    parameter int DWELL_CYCLES = SGA_DWELL_CYCLES,
    parameter int BLANK_CYCLES = SGA_BLANK_CYCLES
) (
    input  logic                 clock,
    input  logic                 restart,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [ROWS-1:0]      row_sel_n,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_done,
    output logic [2:0]           db_row,
    output logic [1:0]           db_state
);

    localparam int CNT_W = timer_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_e            state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [ROWS*COLS-1:0]   display_q, display_d;
    logic [ROWS*COLS-1:0]   pending_q, pending_d;
    logic                   pending_full_q, pending_full_d;
    logic                   frame_done_q, frame_done_d;

    logic                   timer_load;
    logic [CNT_W-1:0]       timer_value;
    logic                   cnt_zero;
    logic                   transfer;
    logic [COLS-1:0]        disp_row [ROWS];

    led_row_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock      (clock),
        .restart    (restart),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (cnt_zero)
    );

    assign frame_ready = (state_q == ST_IDLE) || !pending_full_q;
    assign transfer    = frame_valid && frame_ready;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        display_d      = display_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = 1'b0;
        timer_load     = 1'b0;
        timer_value    = '0;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    display_d   = frame;
                    row_d       = '0;
                    state_d     = ST_BLANK;
                    timer_load  = 1'b1;
                    timer_value = BLANK_LOAD;
                end
            end
            ST_BLANK: begin
                if (cnt_zero) begin
                    state_d     = ST_ON;
                    timer_load  = 1'b1;
                    timer_value = DWELL_LOAD;
                end
            end
            ST_ON: begin
                if (cnt_zero) begin
                    state_d     = ST_BLANK;
                    timer_load  = 1'b1;
                    timer_value = BLANK_LOAD;
                    if (row_q == ROW_LAST) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        if (pending_full_q) begin
                            display_d      = pending_q;
                            pending_full_d = 1'b0;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame landing on the boundary edge saw pending empty, so it waits a full scan.
        if (transfer && (state_q != ST_IDLE)) begin
            pending_d      = frame;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            display_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            display_q      <= display_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_done_q   <= frame_done_d;
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
        assign disp_row[gi]  = display_q[gi*COLS +: COLS];
        assign row_sel_n[gi] = !((state_q == ST_ON) && (row_q == ROW_W'(gi)));
    end

    assign col_data   = (state_q == ST_ON) ? disp_row[row_q] : '0;
    assign frame_done = frame_done_q;
    assign db_row     = 3'(row_q);
    assign db_state   = state_q;

endmodule
